// File: rtl/hazard_scoreboard_unit_if.sv
// rtl/hazard_scoreboard_unit_if.sv - ID-stage hazard scoreboard bus interface
// Purpose : bundles the ID-stage request signals and the stall/control
//           responses exchanged between the decode stage and the hazard
//           scoreboard unit.
// Signals : id_valid, rd_en[1:0], rd_reg1, rd_reg2, wrt_reg, wrt_sel,
//           ser_req, flush          (driven by the decode stage, master)
//           stall, enPC, enIFID, idex_nop, ser_busy, stall_cnt
//                                   (driven by the scoreboard, slave)
interface hazard_scoreboard_unit_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [1:0]       rd_en;
    logic [REG_W-1:0] rd_reg1;
    logic [REG_W-1:0] rd_reg2;
    logic             wrt_reg;
    logic [REG_W-1:0] wrt_sel;
    logic             ser_req;
    logic             flush;
    logic             stall;
    logic             enPC;
    logic             enIFID;
    logic             idex_nop;
    logic             ser_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, rd_en, rd_reg1, rd_reg2, wrt_reg, wrt_sel, ser_req, flush,
        input  stall, enPC, enIFID, idex_nop, ser_busy, stall_cnt
    );

    modport slave (
        input  id_valid, rd_en, rd_reg1, rd_reg2, wrt_reg, wrt_sel, ser_req, flush,
        output stall, enPC, enIFID, idex_nop, ser_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - RAW hazard / serialisation controller for the ID stage
// Purpose : tracks in-flight register writes with one shift mask per
//           architectural register, raises stall on read-after-write
//           hazards, drains the pipe for siic/rti, squashes flushed
//           writes and counts stalled cycles (saturating).
// Ports   : clk  - clock, rising edge
//           rst  - asynchronous active-high reset
//           bus  - hazard_scoreboard_unit_if.slave
//                  in : id_valid, rd_en, rd_reg1, rd_reg2, wrt_reg,
//                       wrt_sel, ser_req, flush
//                  out: stall, enPC, enIFID, idex_nop, ser_busy, stall_cnt
module hazard_scoreboard_unit #(
    parameter int NUM_REGS  = 8,
    parameter int DEPTH     = 3,
    parameter int WB_BYPASS = 1,
    parameter int FLUSH_N   = 1,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    hazard_scoreboard_unit_if.slave  bus
);
    localparam int REG_W = $clog2(NUM_REGS);

    // With a write-before-read register file, bit 0 (write lands this
    // cycle) is already visible to the reader and is not a hazard.
    localparam logic [DEPTH-1:0] LIVE = (WB_BYPASS != 0) ? ~DEPTH'(1) : {DEPTH{1'b1}};

    // A flush removes the FLUSH_N youngest issue slots, i.e. the writes
    // issued during the last FLUSH_N cycles, which occupy the top bits
    // of each mask before this cycle's shift.
    localparam logic [DEPTH-1:0] KEEP = {DEPTH{1'b1}} >> FLUSH_N;

    typedef enum logic {IDLE, DRAIN} state_t;

    logic [DEPTH-1:0] mask      [NUM_REGS];
    logic [DEPTH-1:0] mask_next [NUM_REGS];
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;

    logic             sb_empty;
    logic             raw;
    logic             stall_i;
    logic             issue;
    logic [DEPTH-1:0] src1_mask;
    logic [DEPTH-1:0] src2_mask;

    assign src1_mask = mask[bus.rd_reg1];
    assign src2_mask = mask[bus.rd_reg2];

    assign raw = bus.id_valid & ((bus.rd_en[1] & |(src1_mask & LIVE)) |
                                 (bus.rd_en[0] & |(src2_mask & LIVE)));

    always_comb begin
        sb_empty = 1'b1;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (|mask[r]) begin
                sb_empty = 1'b0;
            end
        end
    end

    // Flush overrides everything: the front end is being redirected, so
    // the ID instruction neither stalls nor issues.
    assign stall_i = ~rst & ~bus.flush &
                     (raw |
                      (bus.id_valid & bus.ser_req & ~sb_empty) |
                      ((state == DRAIN) & ~sb_empty));

    assign issue = bus.id_valid & ~stall_i & ~bus.flush;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            mask_next[r] = (bus.flush ? (mask[r] & KEEP) : mask[r]) >> 1;
            if (issue && bus.wrt_reg && (REG_W'(r) == bus.wrt_sel)) begin
                mask_next[r][DEPTH-1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mask[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mask[r] <= mask_next[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.id_valid && bus.ser_req && !(sb_empty && !raw) && !bus.flush) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Leaving on sb_empty lets the waiting instruction issue in
                // the same cycle; leaving on flush abandons the request.
                if (sb_empty || bus.flush) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (stall_i && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bus.stall     = stall_i;
    assign bus.enPC      = ~stall_i;
    assign bus.enIFID    = ~stall_i;
    assign bus.idex_nop  = stall_i | ~bus.id_valid;
    assign bus.ser_busy  = (state == DRAIN);
    assign bus.stall_cnt = cnt;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - directed self-checking bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit_if #(.REG_W(3), .CNT_W(16)) ia ();
    hazard_scoreboard_unit_if #(.REG_W(3), .CNT_W(16)) ib ();
    hazard_scoreboard_unit_if #(.REG_W(3), .CNT_W(4))  ic ();

    hazard_scoreboard_unit ua (.clk(clk), .rst(rst), .bus(ia));
    hazard_scoreboard_unit #(.WB_BYPASS(0)) ub (.clk(clk), .rst(rst), .bus(ib));
    hazard_scoreboard_unit #(.CNT_W(4)) uc (.clk(clk), .rst(rst), .bus(ic));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic drv_a(input logic v, input logic [1:0] re, input logic [2:0] r1,
                         input logic [2:0] r2, input logic w, input logic [2:0] ws,
                         input logic sr, input logic fl);
        ia.id_valid = v; ia.rd_en = re; ia.rd_reg1 = r1; ia.rd_reg2 = r2;
        ia.wrt_reg = w; ia.wrt_sel = ws; ia.ser_req = sr; ia.flush = fl;
    endtask

    task automatic drv_b(input logic v, input logic [1:0] re, input logic [2:0] r1,
                         input logic [2:0] r2, input logic w, input logic [2:0] ws);
        ib.id_valid = v; ib.rd_en = re; ib.rd_reg1 = r1; ib.rd_reg2 = r2;
        ib.wrt_reg = w; ib.wrt_sel = ws; ib.ser_req = 1'b0; ib.flush = 1'b0;
    endtask

    task automatic drv_c(input logic v, input logic [1:0] re, input logic [2:0] r1,
                         input logic w, input logic [2:0] ws);
        ic.id_valid = v; ic.rd_en = re; ic.rd_reg1 = r1; ic.rd_reg2 = 3'd0;
        ic.wrt_reg = w; ic.wrt_sel = ws; ic.ser_req = 1'b0; ic.flush = 1'b0;
    endtask

    initial begin
        drv_a(1'b1, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        drv_b(1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0);
        drv_c(1'b0, 2'b00, 3'd0, 1'b0, 3'd0);

        // Reset state
        #3;
        chk("rst_stall",    ia.stall, 1'b0);
        chk("rst_enPC",     ia.enPC, 1'b1);
        chk("rst_enIFID",   ia.enIFID, 1'b1);
        chk("rst_idex_nop", ia.idex_nop, 1'b0);
        chk("rst_ser_busy", ia.ser_busy, 1'b0);
        chk("rst_cnt",      ia.stall_cnt, 32'd0);
        chk("rst_idex_nop_b", ib.idex_nop, 1'b1);
        nxt(); rst = 1'b0;
        drv_a(1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);

        // Default params: write R3, then read R3 -> 2 stall cycles
        nxt(); drv_a(1'b1, 2'b00, 3'd0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0); #1;
        chk("t1_wr_nostall", ia.stall, 1'b0);
        nxt(); drv_a(1'b1, 2'b10, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); #1;
        chk("t1_c1_stall", ia.stall, 1'b1);
        chk("t1_c1_enPC", ia.enPC, 1'b0);
        chk("t1_c1_idex_nop", ia.idex_nop, 1'b1);
        nxt(); #1;
        chk("t1_c2_stall", ia.stall, 1'b1);
        nxt(); #1;
        chk("t1_c3_stall", ia.stall, 1'b0);
        chk("t1_c3_enIFID", ia.enIFID, 1'b1);
        chk("t1_cnt", ia.stall_cnt, 32'd2);

        // WB_BYPASS=0: write R3, read R3 via rd_reg2 -> 3 stall cycles
        drv_a(1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        nxt(); drv_b(1'b1, 2'b00, 3'd0, 3'd0, 1'b1, 3'd3); #1;
        chk("b_wr_nostall", ib.stall, 1'b0);
        nxt(); drv_b(1'b1, 2'b01, 3'd0, 3'd3, 1'b0, 3'd0); #1;
        chk("b_c1_stall", ib.stall, 1'b1);
        nxt(); #1;
        chk("b_c2_stall", ib.stall, 1'b1);
        nxt(); #1;
        chk("b_c3_stall", ib.stall, 1'b1);
        nxt(); #1;
        chk("b_c4_stall", ib.stall, 1'b0);
        chk("b_cnt", ib.stall_cnt, 32'd3);
        nxt(); drv_b(1'b1, 2'b00, 3'd0, 3'd0, 1'b1, 3'd4); #1;
        chk("b_wr4_nostall", ib.stall, 1'b0);
        nxt(); drv_b(1'b1, 2'b00, 3'd4, 3'd4, 1'b0, 3'd0); #1;
        chk("b_rden0_nostall", ib.stall, 1'b0);
        nxt(); drv_b(1'b0, 2'b11, 3'd4, 3'd4, 1'b0, 3'd0); #1;
        chk("b_novalid_stall", ib.stall, 1'b0);
        chk("b_novalid_nop", ib.idex_nop, 1'b1);
        nxt(); drv_b(1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0);

        // Flush: write R5, flush next cycle (with a competing write to R6)
        drv_a(1'b1, 2'b00, 3'd0, 3'd0, 1'b1, 3'd5, 1'b0, 1'b0); #1;
        chk("fl_wr_nostall", ia.stall, 1'b0);
        nxt(); drv_a(1'b1, 2'b10, 3'd5, 3'd0, 1'b1, 3'd6, 1'b0, 1'b1); #1;
        chk("fl_forces_nostall", ia.stall, 1'b0);
        chk("fl_enPC", ia.enPC, 1'b1);
        nxt(); drv_a(1'b1, 2'b11, 3'd5, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0); #1;
        chk("fl_r5_r6_nostall", ia.stall, 1'b0);
        // Scoreboard fully empty: a serialising instruction goes straight through
        nxt(); drv_a(1'b1, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0); #1;
        chk("fl_empty_ser_nostall", ia.stall, 1'b0);
        nxt(); drv_a(1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); #1;
        chk("fl_ser_idle", ia.ser_busy, 1'b0);
        chk("fl_cnt", ia.stall_cnt, 32'd2);

        // Serialisation: write R1, write R2, then siic waits for drain
        nxt(); drv_a(1'b1, 2'b00, 3'd0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0);
        nxt(); drv_a(1'b1, 2'b00, 3'd0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0);
        nxt(); drv_a(1'b1, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0); #1;
        chk("ser_c0_stall", ia.stall, 1'b1);
        chk("ser_c0_busy", ia.ser_busy, 1'b0);
        nxt(); #1;
        chk("ser_c1_stall", ia.stall, 1'b1);
        chk("ser_c1_busy", ia.ser_busy, 1'b1);
        nxt(); #1;
        chk("ser_c2_stall", ia.stall, 1'b1);
        chk("ser_c2_busy", ia.ser_busy, 1'b1);
        nxt(); #1;
        chk("ser_c3_issue", ia.stall, 1'b0);
        chk("ser_c3_busy", ia.ser_busy, 1'b1);
        nxt(); drv_a(1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); #1;
        chk("ser_idle", ia.ser_busy, 1'b0);
        chk("ser_cnt", ia.stall_cnt, 32'd5);

        // Async reset in the middle of DRAIN with a pending write
        nxt(); drv_a(1'b1, 2'b00, 3'd0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0);
        nxt(); drv_a(1'b1, 2'b10, 3'd1, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0); #1;
        chk("rd_c0_stall", ia.stall, 1'b1);
        nxt(); #1;
        chk("rd_c1_busy", ia.ser_busy, 1'b1);
        chk("rd_c1_stall", ia.stall, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("rd_async_stall", ia.stall, 1'b0);
        chk("rd_async_busy", ia.ser_busy, 1'b0);
        chk("rd_async_cnt", ia.stall_cnt, 32'd0);
        chk("rd_async_enPC", ia.enPC, 1'b1);
        chk("rd_async_nop", ia.idex_nop, 1'b0);
        nxt(); rst = 1'b0; #1;
        chk("rd_after_stall", ia.stall, 1'b0);
        chk("rd_after_busy", ia.ser_busy, 1'b0);
        nxt(); drv_a(1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);

        // CNT_W=4: read-and-write R3 held constant -> stall 2 of every 3 cycles
        drv_c(1'b1, 2'b10, 3'd3, 1'b1, 3'd3); #1;
        chk("sat_c0_stall", ic.stall, 1'b0);
        repeat (9) nxt();
        #1;
        chk("sat_c9_stall", ic.stall, 1'b0);
        chk("sat_cnt6", ic.stall_cnt, 32'd6);
        repeat (30) nxt();
        #1;
        chk("sat_cnt15", ic.stall_cnt, 32'd15);
        drv_c(1'b0, 2'b00, 3'd0, 1'b0, 3'd0);
        nxt(); nxt(); #1;
        chk("sat_cnt_hold", ic.stall_cnt, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
